ahb_apb_bridge_multi: RTL and testbench
=======================================

Name: ahb_apb_bridge_multi

Overview:
- Parametrised successor AHB-to-APB bridge: one AHB-Lite slave port fanned out to NUM_SLAVES APB slaves through a one-hot Pselx.
- Adds APB wait states (Pready), per-slave address decode, back-to-back transfer acceptance and optional Pslverr-to-AHB ERROR mapping.
- Sits between the AHB interconnect and the peripheral APB segment.

Parameters:
- ADDR_W, 32, AHB/APB address width
- DATA_W, 32, AHB/APB data width
- NUM_SLAVES, 4, number of APB slaves (1..16)
- SLV_SEL_LSB, 12, lowest Haddr bit of the slave-index field; field width is clog2(NUM_SLAVES), minimum 1

Ports:
- Hclk  in  1  clock
- Hresetn  in  1  asynchronous active-low reset
- Hsel  in  1  bridge selected by AHB decoder
- Haddr  in  ADDR_W  AHB address
- Htrans  in  2  AHB transfer type
- Hwrite  in  1  1=write
- Hwdata  in  DATA_W  AHB write data (data phase)
- Hreadyin  in  1  bus-wide HREADY
- Hreadyout  out  1  bridge ready
- Hresp  out  2  00 OKAY, 01 ERROR
- Hrdata  out  DATA_W  read data
- Paddr  out  ADDR_W  APB address
- Pselx  out  NUM_SLAVES  one-hot APB select
- Penable  out  1  APB enable
- Pwrite  out  1  APB direction
- Pwdata  out  DATA_W  APB write data
- Prdata  in  DATA_W  muxed APB read data
- Pready  in  1  APB ready
- Pslverr  in  1  APB slave error

Behaviour:
- Reset (async, Hresetn=0): state IDLE; Hreadyout=1, Hresp=00, Hrdata=0, Paddr=0, Pselx=0, Penable=0, Pwrite=0, Pwdata=0. Reset mid-transfer aborts immediately; no completion is signalled.
- valid = Hsel & Htrans[1] & Hreadyin (NONSEQ/SEQ). IDLE/BUSY transfers get a zero-wait OKAY.
- Valid is sampled in IDLE, DONE and ERR2. On valid: latch Haddr, Hwrite and decoded index; go ADDR.
- ADDR: Hreadyout=0. Latch Hwdata into Pwdata if write. If index >= NUM_SLAVES, go ERR1 (see option); else go SETUP.
- SETUP: Pselx[idx]=1, Penable=0, Paddr/Pwrite driven from latches, Hreadyout=0; always go ACCESS.
- ACCESS: Penable=1, Pselx held, Hreadyout=0. Wait here while Pready=0, with no timeout.
- ACCESS with Pready=1: capture Prdata into Hrdata on reads (writes leave Hrdata unchanged); drop Pselx and Penable; go DONE, or ERR1 if Pslverr=1 and the option is enabled.
- DONE: Hreadyout=1, Hresp=00 for one cycle, then ADDR if valid, else IDLE.
- ERR1: Hreadyout=0, Hresp=01. ERR2: Hreadyout=1, Hresp=01; a valid transfer in ERR2 is accepted, otherwise go IDLE.
- Minimum latency from address phase to Hreadyout high: 4 cycles (ADDR, SETUP, ACCESS, DONE), plus one per Pready=0 cycle.
- Paddr, Pwrite and Pwdata stay stable from SETUP through the final ACCESS. Pselx is never multi-hot.
- Hrdata holds its value until the next read completes.

Optional Feature:
- Macro AHB2APB_PSLVERR_EN.
- Defined: Pslverr=1 at completion, and any out-of-range index, produce the two-cycle ERROR response (ERR1 then ERR2).
- Undefined: Pslverr is ignored and all completions are OKAY. An out-of-range index goes ADDR to DONE with no Psel, Hrdata=0 on reads, writes dropped.

Decomposition:
- Package ahb_apb_pkg: Htrans encodings (IDLE, BUSY, NONSEQ, SEQ), Hresp codes (OKAY, ERROR), state enum (IDLE, ADDR, SETUP, ACCESS, DONE, ERR1, ERR2).
- Sub-module apb_slave_decoder: combinational Haddr to index, one-hot select and in-range flag.

Test Plan:
- Single write, Haddr=0x0000_2004, Hwdata=0xDEAD_BEEF, Pready=1 -> Pselx=0100, Paddr=0x2004, Pwdata=0xDEADBEEF in SETUP+ACCESS; Hreadyout high 4 cycles after address phase, Hresp=00.
- Read from slave 1 with Pready low 3 cycles, Prdata=0x1234_5678 -> Penable held 4 cycles; Hrdata=0x12345678 with Hreadyout=1 on cycle 7.
- Back-to-back write then read issued in DONE -> second SETUP directly follows ADDR; no IDLE cycle; Pselx never multi-hot.
- With AHB2APB_PSLVERR_EN, Pslverr=1 on a read -> Hresp=01 for 2 cycles, Hreadyout 0 then 1. Without the macro, same stimulus -> Hresp=00.
- NUM_SLAVES=3, access to index 3 -> no Pselx asserted; ERROR (enabled) or OKAY with Hrdata=0 (disabled).
- Hresetn asserted in ACCESS -> all outputs return to reset values asynchronously; next transfer after release behaves normally.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the multi-slave AHB-to-APB bridge.
// Transfer types, response codes, FSM states, select-field width.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_multi_if.sv
// AHB-Lite slave side and APB master side of the bridge.
// slave: bridge view; master: AHB/APB environment view.
interface ahb_apb_bridge_multi_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4
);

  logic                  Hsel;
  logic [ADDR_W-1:0]     Haddr;
  logic [1:0]            Htrans;
  logic                  Hwrite;
  logic [DATA_W-1:0]     Hwdata;
  logic                  Hreadyin;
  logic                  Hreadyout;
  logic [1:0]            Hresp;
  logic [DATA_W-1:0]     Hrdata;
  logic [ADDR_W-1:0]     Paddr;
  logic [NUM_SLAVES-1:0] Pselx;
  logic                  Penable;
  logic                  Pwrite;
  logic [DATA_W-1:0]     Pwdata;
  logic [DATA_W-1:0]     Prdata;
  logic                  Pready;
  logic                  Pslverr;

  modport slave (
    input  Hsel, Haddr, Htrans, Hwrite,
    input  Hwdata, Hreadyin,
    input  Prdata, Pready, Pslverr,
    output Hreadyout, Hresp, Hrdata,
    output Paddr, Pselx, Penable,
    output Pwrite, Pwdata
  );

  modport master (
    output Hsel, Haddr, Htrans, Hwrite,
    output Hwdata, Hreadyin,
    output Prdata, Pready, Pslverr,
    input  Hreadyout, Hresp, Hrdata,
    input  Paddr, Pselx, Penable,
    input  Pwrite, Pwdata
  );

endinterface

// File: rtl/apb_slave_decoder.sv
// Haddr to APB slave index, one-hot select and in-range flag.
// Select field starts at SLV_SEL_LSB, at least one bit wide.
module apb_slave_decoder
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int SLV_SEL_LSB = 12,
  parameter int SW          = sel_w(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0]     haddr,
  output logic [SW-1:0]         idx,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  in_range
);

  localparam logic [SW:0] NS = (SW+1)'(NUM_SLAVES);

  logic unused_addr;

  assign idx         = haddr[SLV_SEL_LSB +: SW];
  assign in_range    = {1'b0, idx} < NS;
  assign unused_addr = ^haddr;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == SW'(i)) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_multi.sv
// AHB-Lite to multi-slave APB bridge with wait states.
// Define AHB2APB_PSLVERR_EN to map Pslverr/out-of-range to ERROR.
module ahb_apb_bridge_multi
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int SLV_SEL_LSB = 12
) (
  input logic                  Hclk,
  input logic                  Hresetn,
  ahb_apb_bridge_multi_if.slave bus
);

  localparam int SW = sel_w(NUM_SLAVES);

  state_e st, nx;

  logic [ADDR_W-1:0]     addr_q;
  logic                  wr_q;
  logic                  inr_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [DATA_W-1:0]     pwdata_q;
  logic [DATA_W-1:0]     hrdata_q;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_inr;
  logic [SW-1:0]         unused_idx;
  logic                  valid;
  logic                  take;
  logic                  unused_in;

  apb_slave_decoder #(
    .ADDR_W     (ADDR_W),
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_SEL_LSB(SLV_SEL_LSB),
    .SW         (SW)
  ) u_dec (
    .haddr   (bus.Haddr),
    .idx     (unused_idx),
    .sel     (dec_sel),
    .in_range(dec_inr)
  );

  assign valid = bus.Hsel & bus.Htrans[1]
               & bus.Hreadyin;
  assign take  = valid & ((st == ST_IDLE)
               | (st == ST_DONE)
               | (st == ST_ERR2));

`ifdef AHB2APB_PSLVERR_EN
  assign unused_in = bus.Htrans[0];
`else
  assign unused_in = bus.Htrans[0] ^ bus.Pslverr;
`endif

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) st <= ST_IDLE;
    else          st <= nx;
  end

  always_comb begin
    nx = st;
    unique case (st)
      ST_IDLE:  if (take) nx = ST_ADDR;
      ST_ADDR: begin
`ifdef AHB2APB_PSLVERR_EN
        nx = inr_q ? ST_SETUP : ST_ERR1;
`else
        nx = inr_q ? ST_SETUP : ST_DONE;
`endif
      end
      ST_SETUP: nx = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.Pready) begin
`ifdef AHB2APB_PSLVERR_EN
          nx = bus.Pslverr ? ST_ERR1 : ST_DONE;
`else
          nx = ST_DONE;
`endif
        end
      end
      ST_DONE:  nx = take ? ST_ADDR : ST_IDLE;
      ST_ERR1:  nx = ST_ERR2;
      ST_ERR2:  nx = take ? ST_ADDR : ST_IDLE;
      default:  nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.Hreadyout = 1'b0;
    bus.Hresp     = RESP_OKAY;
    bus.Pselx     = '0;
    bus.Penable   = 1'b0;
    unique case (st)
      ST_IDLE, ST_DONE: bus.Hreadyout = 1'b1;
      ST_SETUP:  bus.Pselx = sel_q;
      ST_ACCESS: begin
        bus.Pselx   = sel_q;
        bus.Penable = 1'b1;
      end
      ST_ERR1: bus.Hresp = RESP_ERROR;
      ST_ERR2: begin
        bus.Hreadyout = 1'b1;
        bus.Hresp     = RESP_ERROR;
      end
      default: ;
    endcase
  end

  assign bus.Paddr  = addr_q;
  assign bus.Pwrite = wr_q;
  assign bus.Pwdata = pwdata_q;
  assign bus.Hrdata = hrdata_q;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      addr_q   <= '0;
      wr_q     <= 1'b0;
      inr_q    <= 1'b0;
      sel_q    <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      if (take) begin
        addr_q <= bus.Haddr;
        wr_q   <= bus.Hwrite;
        sel_q  <= dec_sel;
        inr_q  <= dec_inr;
      end
      if (st == ST_ADDR && wr_q)
        pwdata_q <= bus.Hwdata;
`ifndef AHB2APB_PSLVERR_EN
      // unmapped reads return zero
      if (st == ST_ADDR && !wr_q && !inr_q)
        hrdata_q <= '0;
`endif
      if (st == ST_ACCESS && bus.Pready && !wr_q)
        hrdata_q <= bus.Prdata;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_multi.sv
// Directed bench: 4-slave bridge plus a 3-slave copy.
// The 3-slave copy exercises the unmapped index.
module tb_ahb_apb_bridge_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb_apb_bridge_multi_if #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4)
  ) b4 ();
  ahb_apb_bridge_multi_if #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)
  ) b3 ();

  ahb_apb_bridge_multi #(
    .ADDR_W(32), .DATA_W(32),
    .NUM_SLAVES(4), .SLV_SEL_LSB(12)
  ) u4 (.Hclk(clk), .Hresetn(rst_n), .bus(b4));

  ahb_apb_bridge_multi #(
    .ADDR_W(32), .DATA_W(32),
    .NUM_SLAVES(3), .SLV_SEL_LSB(12)
  ) u3 (.Hclk(clk), .Hresetn(rst_n), .bus(b3));

  logic        use3, hsel, hwrite;
  logic        pready, pslverr;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata, prdata;

  assign b4.Hsel     = hsel & ~use3;
  assign b3.Hsel     = hsel & use3;
  assign b4.Haddr    = haddr;
  assign b3.Haddr    = haddr;
  assign b4.Htrans   = htrans;
  assign b3.Htrans   = htrans;
  assign b4.Hwrite   = hwrite;
  assign b3.Hwrite   = hwrite;
  assign b4.Hwdata   = hwdata;
  assign b3.Hwdata   = hwdata;
  assign b4.Hreadyin = b4.Hreadyout;
  assign b3.Hreadyin = b3.Hreadyout;
  assign b4.Prdata   = prdata;
  assign b3.Prdata   = prdata;
  assign b4.Pready   = pready;
  assign b3.Pready   = pready;
  assign b4.Pslverr  = pslverr;
  assign b3.Pslverr  = pslverr;

  logic        o_rdy, o_pen, o_pwrite;
  logic [1:0]  o_resp;
  logic [3:0]  o_psel;
  logic [31:0] o_rdata, o_paddr, o_pwdata;

  assign o_rdy    = use3 ? b3.Hreadyout : b4.Hreadyout;
  assign o_resp   = use3 ? b3.Hresp : b4.Hresp;
  assign o_rdata  = use3 ? b3.Hrdata : b4.Hrdata;
  assign o_paddr  = use3 ? b3.Paddr : b4.Paddr;
  assign o_psel   = use3 ? {1'b0, b3.Pselx} : b4.Pselx;
  assign o_pen    = use3 ? b3.Penable : b4.Penable;
  assign o_pwrite = use3 ? b3.Pwrite : b4.Pwrite;
  assign o_pwdata = use3 ? b3.Pwdata : b4.Pwdata;

  int checks = 0;
  int errors = 0;

  int          r_done, r_err, r_pen, r_pselc;
  logic [1:0]  r_resp;
  logic [3:0]  r_psel;
  logic [31:0] r_paddr, r_pwdata;
  logic        r_pwrite, r_multi;

  // cycle 0 is the address phase; results are
  // cycle numbers relative to it
  task automatic xfer(input bit d3,
                      input logic [31:0] a,
                      input bit w,
                      input logic [31:0] wd,
                      input logic [31:0] rd,
                      input int waits,
                      input bit err);
    @(posedge clk); #1;
    use3 = d3; hsel = 1'b1;
    htrans = 2'b10; haddr = a;
    hwrite = w; prdata = rd;
    pslverr = err; pready = (waits == 0);
    r_done = -1; r_err = -1;
    r_pen = 0; r_pselc = 0;
    r_resp = 2'bxx; r_psel = '0;
    r_paddr = '0; r_pwdata = '0;
    r_pwrite = 1'b0; r_multi = 1'b0;
    for (int c = 0; c < 24 && r_done < 0; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 1) begin
          hsel = 1'b0; htrans = 2'b00;
          hwdata = wd;
        end
        pready = (r_pen >= waits);
      end
      @(negedge clk);
      if (c > 0) begin
        if (o_pen) r_pen++;
        if (o_psel != 4'b0) begin
          r_pselc++;
          r_psel = o_psel;
          r_paddr = o_paddr;
          r_pwdata = o_pwdata;
          r_pwrite = o_pwrite;
        end
        if ($countones(o_psel) > 1) r_multi = 1'b1;
        if (o_resp == 2'b01 && r_err < 0) r_err = c;
        if (o_rdy) begin
          r_done = c;
          r_resp = o_resp;
        end
      end
    end
    pslverr = 1'b0;
    pready = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (o_rdy !== 1'b1) begin
      errors++; $display("FAIL rst_hready got %b exp 1", o_rdy);
    end
    checks++;
    if ({o_resp, o_pen, o_pwrite, o_psel} !== 8'h00) begin
      errors++;
      $display("FAIL rst_ctrl got %h exp 00",
               {o_resp, o_pen, o_pwrite, o_psel});
    end
    checks++;
    if ({o_rdata, o_paddr, o_pwdata} !== 96'h0) begin
      errors++;
      $display("FAIL rst_data got %h exp 0",
               {o_rdata, o_paddr, o_pwdata});
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_write();
    xfer(1'b0, 32'h0000_2004, 1'b1,
         32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    checks++;
    if (r_done !== 4) begin
      errors++; $display("FAIL wr_latency got %0d exp 4", r_done);
    end
    checks++;
    if (r_resp !== 2'b00) begin
      errors++; $display("FAIL wr_resp got %b exp 00", r_resp);
    end
    checks++;
    if (r_psel !== 4'b0100 || r_pselc !== 2) begin
      errors++;
      $display("FAIL wr_psel got %b x%0d exp 0100 x2",
               r_psel, r_pselc);
    end
    checks++;
    if (r_paddr !== 32'h2004 || r_pwrite !== 1'b1) begin
      errors++;
      $display("FAIL wr_paddr got %h/%b exp 00002004/1",
               r_paddr, r_pwrite);
    end
    checks++;
    if (r_pwdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_pwdata got %h exp deadbeef", r_pwdata);
    end
  endtask

  task automatic test_read_wait();
    xfer(1'b0, 32'h0000_1000, 1'b0,
         32'h0, 32'h1234_5678, 3, 1'b0);
    checks++;
    if (r_done !== 7) begin
      errors++; $display("FAIL rd_latency got %0d exp 7", r_done);
    end
    checks++;
    if (r_pen !== 4) begin
      errors++; $display("FAIL rd_penable got %0d exp 4", r_pen);
    end
    checks++;
    if (r_psel !== 4'b0010) begin
      errors++; $display("FAIL rd_psel got %b exp 0010", r_psel);
    end
    checks++;
    if (o_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL rd_hrdata got %h exp 12345678", o_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    logic       multi;
    multi = 1'b0;
    @(posedge clk); #1;
    use3 = 1'b0; pready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 0) begin
        hsel = 1'b1; htrans = 2'b10;
        haddr = 32'h0000_3000; hwrite = 1'b1;
      end
      if (c == 1) begin
        hsel = 1'b0; htrans = 2'b00;
        hwdata = 32'h0BAD_F00D;
      end
      if (c == 4) begin
        hsel = 1'b1; htrans = 2'b10;
        haddr = 32'h0000_0010; hwrite = 1'b0;
        prdata = 32'hCAFE_0001;
      end
      if (c == 5) begin
        hsel = 1'b0; htrans = 2'b00;
      end
      @(negedge clk);
      if ($countones(o_psel) > 1) multi = 1'b1;
      if (c > 0) begin
        case (c)
          2:       exp = 6'b00_1000;
          3:       exp = 6'b01_1000;
          4, 8, 9: exp = 6'b10_0000;
          6:       exp = 6'b00_0001;
          7:       exp = 6'b01_0001;
          default: exp = 6'b00_0000;
        endcase
        checks++;
        if ({o_rdy, o_pen, o_psel} !== exp) begin
          errors++;
          $display("FAIL b2b_c%0d got %b exp %b",
                   c, {o_rdy, o_pen, o_psel}, exp);
        end
      end
      if (c == 2) begin
        checks++;
        if (o_pwdata !== 32'h0BAD_F00D || o_pwrite !== 1'b1) begin
          errors++;
          $display("FAIL b2b_wdata got %h/%b exp 0badf00d/1",
                   o_pwdata, o_pwrite);
        end
      end
      if (c == 4) begin
        checks++;
        if (o_rdata !== 32'h1234_5678) begin
          errors++; $display("FAIL b2b_hold got %h exp 12345678", o_rdata);
        end
      end
      if (c == 6) begin
        checks++;
        if (o_paddr !== 32'h10 || o_pwrite !== 1'b0) begin
          errors++;
          $display("FAIL b2b_raddr got %h/%b exp 00000010/0",
                   o_paddr, o_pwrite);
        end
      end
      if (c == 8) begin
        checks++;
        if (o_rdata !== 32'hCAFE_0001) begin
          errors++; $display("FAIL b2b_rdata got %h exp cafe0001", o_rdata);
        end
      end
    end
    checks++;
    if (multi !== 1'b0) begin
      errors++; $display("FAIL b2b_onehot got multi-hot exp one-hot");
    end
  endtask

  task automatic test_slverr();
    int         e_done, e_err;
    logic [1:0] e_resp;
`ifdef AHB2APB_PSLVERR_EN
    e_done = 5; e_err = 4; e_resp = 2'b01;
`else
    e_done = 4; e_err = -1; e_resp = 2'b00;
`endif
    xfer(1'b0, 32'h0000_2008, 1'b0,
         32'h0, 32'h55AA_55AA, 0, 1'b1);
    checks++;
    if (r_done !== e_done || r_err !== e_err) begin
      errors++;
      $display("FAIL err_timing got %0d/%0d exp %0d/%0d",
               r_done, r_err, e_done, e_err);
    end
    checks++;
    if (r_resp !== e_resp) begin
      errors++; $display("FAIL err_resp got %b exp %b", r_resp, e_resp);
    end
    checks++;
    if (o_rdata !== 32'h55AA_55AA) begin
      errors++; $display("FAIL err_rdata got %h exp 55aa55aa", o_rdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({o_rdy, o_resp} !== 3'b100) begin
      errors++;
      $display("FAIL err_after got %b exp 100", {o_rdy, o_resp});
    end
  endtask

  task automatic test_out_of_range();
    int         e_done;
    logic [1:0] e_resp;
`ifdef AHB2APB_PSLVERR_EN
    e_done = 3; e_resp = 2'b01;
`else
    e_done = 2; e_resp = 2'b00;
`endif
    xfer(1'b1, 32'h0000_2000, 1'b0,
         32'h0, 32'hA5A5_A5A5, 0, 1'b0);
    checks++;
    if (r_psel !== 4'b0100 || o_rdata !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL oor_pre got %b/%h exp 0100/a5a5a5a5",
               r_psel, o_rdata);
    end
    xfer(1'b1, 32'h0000_3000, 1'b0,
         32'h0, 32'h1111_1111, 0, 1'b0);
    checks++;
    if (r_pselc !== 0 || r_pen !== 0) begin
      errors++;
      $display("FAIL oor_psel got %0d/%0d exp 0/0", r_pselc, r_pen);
    end
    checks++;
    if (r_done !== e_done || r_resp !== e_resp) begin
      errors++;
      $display("FAIL oor_resp got %0d/%b exp %0d/%b",
               r_done, r_resp, e_done, e_resp);
    end
`ifndef AHB2APB_PSLVERR_EN
    checks++;
    if (o_rdata !== 32'h0) begin
      errors++; $display("FAIL oor_rdata got %h exp 0", o_rdata);
    end
`endif
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    use3 = 1'b0; hsel = 1'b1; htrans = 2'b10;
    haddr = 32'h0000_1004; hwrite = 1'b0;
    pready = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({o_pen, o_psel} !== 5'b1_0010) begin
      errors++;
      $display("FAIL mid_access got %b exp 10010", {o_pen, o_psel});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_rdy, o_resp, o_pen, o_pwrite, o_psel} !== 9'h100) begin
      errors++;
      $display("FAIL mid_ctrl got %h exp 100",
               {o_rdy, o_resp, o_pen, o_pwrite, o_psel});
    end
    checks++;
    if ({o_rdata, o_paddr, o_pwdata} !== 96'h0) begin
      errors++;
      $display("FAIL mid_data got %h exp 0",
               {o_rdata, o_paddr, o_pwdata});
    end
    @(posedge clk); #1;
    rst_n = 1'b1; pready = 1'b1;
    xfer(1'b0, 32'h0000_2004, 1'b1,
         32'h600D_F00D, 32'h0, 0, 1'b0);
    checks++;
    if (r_done !== 4 || r_psel !== 4'b0100
        || r_pwdata !== 32'h600D_F00D) begin
      errors++;
      $display("FAIL mid_after got %0d/%b/%h exp 4/0100/600df00d",
               r_done, r_psel, r_pwdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    use3 = 1'b0; hsel = 1'b0; htrans = 2'b00;
    haddr = '0; hwrite = 1'b0; hwdata = '0;
    prdata = '0; pready = 1'b1; pslverr = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_slverr();
    test_out_of_range();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
